// File: rtl/zynet_pkg.sv
// Shared types and helpers for the zyNet argmax post-processor.
package zynet_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

  // Helpers work at a fixed wide width; callers sign-extend in and truncate out.
  localparam int unsigned SAT_W = 64;

  // Most-negative two's-complement value of the given width (1 then zeros).
  function automatic logic [SAT_W-1:0] most_neg(input int unsigned width);
    logic [SAT_W-1:0] r;
    r = '0;
    r[width-1] = 1'b1;
    return r;
  endfunction

  // a - b, clamped to the largest positive value representable in width bits.
  function automatic logic signed [SAT_W-1:0] sat_sub(input logic signed [SAT_W-1:0] a,
                                                       input logic signed [SAT_W-1:0] b,
                                                       input int unsigned width);
    logic signed [SAT_W-1:0] diff;
    logic signed [SAT_W-1:0] lim;
    diff = a - b;
    lim  = (SAT_W'(1) << (width - 1)) - SAT_W'(1);
    return (diff > lim) ? lim : diff;
  endfunction

endpackage

// File: rtl/zynet_argmax_compare.sv
// One scan step: fold element e into the running best / runner-up pair.
module argmax_compare_unit #(
  parameter int WORD_SIZE = 16,
  parameter int IDX_W     = 4
) (
  input  logic signed [WORD_SIZE-1:0] elem,
  input  logic [IDX_W-1:0]            idx,
  input  logic signed [WORD_SIZE-1:0] best,
  input  logic [IDX_W-1:0]            best_idx,
  input  logic signed [WORD_SIZE-1:0] second,
  output logic signed [WORD_SIZE-1:0] best_n,
  output logic [IDX_W-1:0]            best_idx_n,
  output logic signed [WORD_SIZE-1:0] second_n
);

  // Strict compare keeps the lowest index on ties; an equal element still
  // lifts the runner-up so the margin reads zero.
  always_comb begin
    best_n     = best;
    best_idx_n = best_idx;
    second_n   = second;
    if (elem > best) begin
      second_n   = best;
      best_n     = elem;
      best_idx_n = idx;
    end else if (elem > second) begin
      second_n = elem;
    end
  end

endmodule

// File: rtl/zynet_argmax.sv
// Serial argmax over the zyNet output vector: winning class, score and margin.
module zynet_argmax
  import zynet_pkg::*;
#(
  parameter int OUTPUT_SIZE = 10,
  parameter int WORD_SIZE   = 16
) (
  input  logic                                  clk_i,
  input  logic                                  reset_n_i,
  input  logic                                  valid_i,
  input  logic [OUTPUT_SIZE-1:0][WORD_SIZE-1:0] data_i,
  output logic                                  yumi_o,
  output logic                                  valid_o,
  input  logic                                  yumi_i,
  output logic [$clog2(OUTPUT_SIZE)-1:0]        class_o,
  output logic [WORD_SIZE-1:0]                  max_o,
  output logic [WORD_SIZE-1:0]                  margin_o
);

  localparam int IDX_W = $clog2(OUTPUT_SIZE);
  localparam logic [WORD_SIZE-1:0] MOST_NEG = WORD_SIZE'(most_neg(WORD_SIZE));

  state_e                                state_q, state_d;
  logic [OUTPUT_SIZE-1:0][WORD_SIZE-1:0] vec_q;
  logic [IDX_W-1:0]                      idx_q, best_idx_q, best_idx_n;
  logic signed [WORD_SIZE-1:0]           best_q, second_q, best_n, second_n, elem;
  logic [IDX_W-1:0]                      class_q;
  logic [WORD_SIZE-1:0]                  max_q, margin_q, margin_n;
  logic                                  last;

  assign elem     = vec_q[idx_q];
  assign last     = (idx_q == IDX_W'(OUTPUT_SIZE - 1));
  assign margin_n = WORD_SIZE'(sat_sub(SAT_W'(best_n), SAT_W'(second_n), WORD_SIZE));

  argmax_compare_unit #(.WORD_SIZE(WORD_SIZE), .IDX_W(IDX_W)) u_cmp (
    .elem      (elem),
    .idx       (idx_q),
    .best      (best_q),
    .best_idx  (best_idx_q),
    .second    (second_q),
    .best_n    (best_n),
    .best_idx_n(best_idx_n),
    .second_n  (second_n)
  );

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) state_q <= IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    yumi_o  = (state_q == IDLE) & valid_i & reset_n_i;
    case (state_q)
      IDLE:    if (valid_i) state_d = SCAN;
      SCAN:    if (last)    state_d = DONE;
      DONE:    if (yumi_i)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      vec_q      <= '0;
      idx_q      <= '0;
      best_q     <= '0;
      best_idx_q <= '0;
      second_q   <= '0;
      class_q    <= '0;
      max_q      <= '0;
      margin_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (valid_i) begin
          // Element 0 seeds the scan, so SCAN starts at index 1.
          vec_q      <= data_i;
          best_q     <= data_i[0];
          best_idx_q <= '0;
          second_q   <= MOST_NEG;
          idx_q      <= IDX_W'(1);
        end
        SCAN: begin
          best_q     <= best_n;
          best_idx_q <= best_idx_n;
          second_q   <= second_n;
          idx_q      <= idx_q + IDX_W'(1);
          if (last) begin
            class_q  <= best_idx_n;
            max_q    <= best_n;
            margin_q <= margin_n;
          end
        end
        default: ;
      endcase
    end
  end

  assign valid_o  = (state_q == DONE);
  assign class_o  = class_q;
  assign max_o    = max_q;
  assign margin_o = margin_q;

endmodule

// File: tb/tb_zynet_argmax.sv
// Self-checking bench for zynet_argmax: table, random, backpressure, reset, streaming.
module tb_zynet_argmax;
  localparam int N = 10;
  localparam int W = 16;
  localparam int IW = $clog2(N);

  typedef logic [N-1:0][W-1:0] vec_t;
  typedef struct {
    vec_t v;
    int   cls;
    int   mx;
    int   mg;
  } rec_t;

  logic           clk = 1'b0;
  logic           reset_n_i;
  logic           valid_i;
  vec_t           data_i;
  logic           yumi_o;
  logic           valid_o;
  logic           yumi_i;
  logic [IW-1:0]  class_o;
  logic [W-1:0]   max_o;
  logic [W-1:0]   margin_o;

  int total = 0;
  int bad   = 0;

  zynet_argmax #(.OUTPUT_SIZE(N), .WORD_SIZE(W)) dut (
    .clk_i    (clk),
    .reset_n_i(reset_n_i),
    .valid_i  (valid_i),
    .data_i   (data_i),
    .yumi_o   (yumi_o),
    .valid_o  (valid_o),
    .yumi_i   (yumi_i),
    .class_o  (class_o),
    .max_o    (max_o),
    .margin_o (margin_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Reference: first index of the maximum; runner-up is the max of everything else.
  function automatic void model(input vec_t v, output int cls, output int mx, output int mg);
    int s[N];
    int sec;
    for (int i = 0; i < N; i++) s[i] = int'($signed(v[i]));
    cls = 0;
    for (int i = 1; i < N; i++) if (s[i] > s[cls]) cls = i;
    mx  = s[cls];
    sec = -(1 << (W - 1));
    for (int i = 0; i < N; i++) if (i != cls && s[i] > sec) sec = s[i];
    mg = mx - sec;
    if (mg > (1 << (W - 1)) - 1) mg = (1 << (W - 1)) - 1;
  endfunction

  // Called just after the accept edge; counts cycles until valid_o.
  task automatic wait_done(output int lat, output bit stray_yumi);
    lat = 1;
    stray_yumi = 1'b0;
    while (!valid_o && lat < 40) begin
      if (yumi_o) stray_yumi = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  // Present v (valid_i held through the scan), wait for the result.
  task automatic run_vec(input vec_t v, input string tag);
    int lat;
    bit stray;
    valid_i = 1'b1;
    data_i  = v;
    #1;
    chk({tag, ".yumi_t0"}, int'(yumi_o), 1);
    @(posedge clk); #1;
    wait_done(lat, stray);
    valid_i = 1'b0;
    chk({tag, ".latency"}, lat, N);
    chk({tag, ".yumi_once"}, int'(stray), 0);
  endtask

  task automatic check_result(input string tag, input int cls, input int mx, input int mg);
    chk({tag, ".class"}, int'(class_o), cls);
    chk({tag, ".max"}, int'($signed(max_o)), mx);
    chk({tag, ".margin"}, int'($signed(margin_o)), mg);
  endtask

  task automatic ack(input string tag);
    yumi_i = 1'b1;
    @(posedge clk); #1;
    yumi_i = 1'b0;
    chk({tag, ".valid_drop"}, int'(valid_o), 0);
  endtask

  function automatic vec_t rand_vec(input int mode);
    vec_t v;
    logic [W-1:0] ext[4];
    ext[0] = 16'h8000; ext[1] = 16'h7FFF; ext[2] = 16'h0000; ext[3] = 16'h0001;
    for (int i = 0; i < N; i++) begin
      case (mode)
        0:       v[i] = W'($urandom);
        1:       v[i] = W'(int'($urandom_range(0, 7)) - 4);
        default: v[i] = ext[$urandom_range(0, 3)];
      endcase
    end
    return v;
  endfunction

  initial begin
    rec_t tbl[5];
    vec_t v, v2, b2b[5];
    int cls, mx, mg, cls2, mx2, mg2, lat;
    bit stray, stable, seen_valid;
    int win[5];
    int rise_c[$], rise_t[$];
    int cyc, k;
    bit acc;

    // Test-plan vectors plus two extra boundaries.
    for (int i = 0; i < N; i++) tbl[0].v[i] = 16'h0100;
    tbl[0].v[7] = 16'h0A00; tbl[0].cls = 7; tbl[0].mx = 'h0A00; tbl[0].mg = 'h0900;
    for (int i = 0; i < N; i++) tbl[1].v[i] = 16'hF000;
    tbl[1].v[2] = 16'hFF00; tbl[1].v[5] = 16'hFF00;
    tbl[1].cls = 2; tbl[1].mx = -256; tbl[1].mg = 0;
    for (int i = 0; i < N; i++) tbl[2].v[i] = 16'h8000;
    tbl[2].v[0] = 16'h7FFF; tbl[2].cls = 0; tbl[2].mx = 32767; tbl[2].mg = 32767;
    for (int i = 0; i < N; i++) tbl[3].v[i] = 16'h1234;
    tbl[3].cls = 0; tbl[3].mx = 'h1234; tbl[3].mg = 0;
    for (int i = 0; i < N; i++) tbl[4].v[i] = W'(i * 3 - 20);
    tbl[4].cls = 9; tbl[4].mx = 7; tbl[4].mg = 3;

    reset_n_i = 1'b0; valid_i = 1'b1; yumi_i = 1'b0; data_i = tbl[0].v;
    repeat (2) @(posedge clk); #1;
    chk("rst.yumi_gated", int'(yumi_o), 0);
    chk("rst.valid", int'(valid_o), 0);
    check_result("rst", 0, 0, 0);
    reset_n_i = 1'b1; valid_i = 1'b0;
    @(posedge clk); #1;

    for (int t = 0; t < 5; t++) begin
      run_vec(tbl[t].v, $sformatf("tbl%0d", t));
      check_result($sformatf("tbl%0d", t), tbl[t].cls, tbl[t].mx, tbl[t].mg);
      ack($sformatf("tbl%0d", t));
    end

    for (int r = 0; r < 30; r++) begin
      v = rand_vec(r % 3);
      model(v, cls, mx, mg);
      run_vec(v, $sformatf("rnd%0d", r));
      check_result($sformatf("rnd%0d", r), cls, mx, mg);
      ack($sformatf("rnd%0d", r));
    end

    // Backpressure: hold the result 20 cycles with a second vector waiting.
    v = rand_vec(0); v2 = rand_vec(1);
    model(v, cls, mx, mg); model(v2, cls2, mx2, mg2);
    run_vec(v, "bp");
    valid_i = 1'b1; data_i = v2;
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (yumi_o !== 1'b0 || valid_o !== 1'b1 || int'(class_o) != cls ||
          int'($signed(max_o)) != mx || int'($signed(margin_o)) != mg) stable = 1'b0;
      @(posedge clk); #1;
    end
    chk("bp.hold_stable", int'(stable), 1);
    yumi_i = 1'b1; #1;
    chk("bp.no_yumi_same_cycle", int'(yumi_o), 0);
    @(posedge clk); #1;
    yumi_i = 1'b0;
    chk("bp.valid_drop", int'(valid_o), 0);
    chk("bp.yumi_next", int'(yumi_o), 1);
    @(posedge clk); #1;
    wait_done(lat, stray);
    valid_i = 1'b0;
    chk("bp2.latency", lat, N);
    check_result("bp2", cls2, mx2, mg2);
    ack("bp2");

    // Reset at t0+4 discards the in-flight vector.
    valid_i = 1'b1; data_i = tbl[0].v;
    @(posedge clk); #1;
    valid_i = 1'b0;
    repeat (3) @(posedge clk); #1;
    reset_n_i = 1'b0;
    @(posedge clk); #1;
    reset_n_i = 1'b1;
    check_result("midrst", 0, 0, 0);
    seen_valid = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (valid_o) seen_valid = 1'b1;
      @(posedge clk); #1;
    end
    chk("midrst.no_valid", int'(seen_valid), 0);
    run_vec(tbl[1].v, "postrst");
    check_result("postrst", tbl[1].cls, tbl[1].mx, tbl[1].mg);
    ack("postrst");

    // Back-to-back with yumi_i tied high.
    win[0] = 9; win[1] = 0; win[2] = 4; win[3] = 9; win[4] = 1;
    for (int j = 0; j < 5; j++) begin
      for (int i = 0; i < N; i++) b2b[j][i] = W'(int'($urandom_range(0, 2000)) - 1000);
      b2b[j][win[j]] = 16'd3000;
    end
    yumi_i = 1'b1; valid_i = 1'b1; data_i = b2b[0];
    cyc = 0; k = 0;
    while (cyc < 100 && rise_c.size() < 5) begin
      #1;
      acc = yumi_o;
      if (valid_o) begin
        rise_c.push_back(int'(class_o));
        rise_t.push_back(cyc);
      end
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        k++;
        if (k < 5) data_i = b2b[k];
        else       valid_i = 1'b0;
      end
    end
    yumi_i = 1'b0; valid_i = 1'b0;
    chk("b2b.count", rise_c.size(), 5);
    for (int j = 0; j < rise_c.size() && j < 5; j++)
      chk($sformatf("b2b.class%0d", j), rise_c[j], win[j]);
    for (int j = 1; j < rise_t.size(); j++)
      chk($sformatf("b2b.gap%0d", j), rise_t[j] - rise_t[j-1], N + 1);
    chk("b2b.first_lat", (rise_t.size() > 0) ? rise_t[0] : -1, N);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
